sw_input_port: RTL and testbench

//  Memory-mapped responder for the board switches. The CPU reads it through MEM-stage loads.
//  - Synchronises and debounces sw[12:0].
//  - Latches change events for polling or interrupt.
//  - Returns register data one cycle after a read, aligned with the MDR pipeline register.

---
 rtl/sw_input_port_pkg.sv | 15 +
 rtl/sw_debounce.sv | 44 ++++
 rtl/sw_input_port.sv | 110 +++++++++++
 tb/tb_sw_input_port.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sw_input_port_pkg.sv
// Shared definitions for the switch input port: register offsets, STATUS bit
// positions and the default bank width, used by both the MEM decode and the port.
package sw_input_port_pkg;

  localparam int SWP_SW_W = 13;

  localparam logic [1:0] SWP_DATA    = 2'd0;
  localparam logic [1:0] SWP_STATUS  = 2'd1;
  localparam logic [1:0] SWP_CHANGED = 2'd2;
  localparam logic [1:0] SWP_EVCNT   = 2'd3;

  localparam int SWP_STATUS_NEW_BIT    = 0;
  localparam int SWP_STATUS_ENABLE_BIT = 1;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus per-bank debounce counter; flags when the current
// candidate level has been stable for DEBOUNCE_CYC cycles.
module sw_debounce #(
  parameter int SW_W         = 13,
  parameter int CNT_W        = 16,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW_W-1:0] sw,
  output logic [SW_W-1:0] cand,
  output logic            ready
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [SW_W-1:0]  meta_reg;
  logic [SW_W-1:0]  sync_reg;
  logic [SW_W-1:0]  cand_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= '0;
      sync_reg <= '0;
      cand_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      meta_reg <= sw;
      sync_reg <= meta_reg;
      if (sync_reg != cand_reg) begin
        cand_reg <= sync_reg;
        cnt_reg  <= '0;
      end else if (cnt_reg != CNT_LAST) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  // The counter saturates, so ready stays high while acceptance is held off.
  assign cand  = cand_reg;
  assign ready = (sync_reg == cand_reg) && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/sw_input_port.sv
// Memory-mapped switch port: debounced level, sticky change mask, event count
// and NEW/ENABLE interrupt, with read data registered to line up with MDR.
module sw_input_port
  import sw_input_port_pkg::*;
#(
  parameter int SW_W         = SWP_SW_W,
  parameter int CNT_W        = 16,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW_W-1:0] sw,
  input  logic            rd_en,
  input  logic            wr_en,
  input  logic [1:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            irq
);

  logic [SW_W-1:0] cand;
  logic            ready;

  sw_debounce #(
    .SW_W        (SW_W),
    .CNT_W       (CNT_W),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .sw   (sw),
    .cand (cand),
    .ready(ready)
  );

  logic [SW_W-1:0] stable_reg;
  logic [SW_W-1:0] changed_reg;
  logic [SW_W-1:0] changed_next;
  logic            new_reg;
  logic            enable_reg;
  logic [7:0]      evcnt_reg;
  logic [31:0]     rdata_reg;
  logic            irq_reg;
  logic [31:0]     rd_mux;
  logic            accept;
  logic            status_wr;
  logic            changed_rd;
  logic            unused_wdata;

  assign accept       = ready && enable_reg && (cand != stable_reg);
  assign status_wr    = wr_en && (addr == SWP_STATUS);
  assign changed_rd   = rd_en && (addr == SWP_CHANGED);
  assign unused_wdata = ^wdata[31:2];

  // A read clears the old mask, but bits set by a same-cycle accept survive.
  genvar gi;
  generate
    for (gi = 0; gi < SW_W; gi++) begin : g_changed
      assign changed_next[gi] = (changed_reg[gi] & ~changed_rd)
                              | (accept & (cand[gi] ^ stable_reg[gi]));
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    case (addr)
      SWP_DATA:    rd_mux[SW_W-1:0] = stable_reg;
      SWP_STATUS: begin
        rd_mux[SWP_STATUS_NEW_BIT]    = new_reg;
        rd_mux[SWP_STATUS_ENABLE_BIT] = enable_reg;
      end
      SWP_CHANGED: rd_mux[SW_W-1:0] = changed_reg;
      SWP_EVCNT:   rd_mux[7:0]      = evcnt_reg;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_reg  <= '0;
      changed_reg <= '0;
      new_reg     <= 1'b0;
      enable_reg  <= 1'b1;
      evcnt_reg   <= '0;
      rdata_reg   <= '0;
      irq_reg     <= 1'b0;
    end else begin
      changed_reg <= changed_next;
      irq_reg     <= new_reg & enable_reg;
      if (rd_en) begin
        rdata_reg <= rd_mux;
      end
      if (status_wr) begin
        enable_reg <= wdata[SWP_STATUS_ENABLE_BIT];
      end
      // Set wins over a write-1-to-clear in the same cycle.
      if (accept) begin
        stable_reg <= cand;
        new_reg    <= 1'b1;
        evcnt_reg  <= evcnt_reg + 8'd1;
      end else if (status_wr && wdata[SWP_STATUS_NEW_BIT]) begin
        new_reg <= 1'b0;
      end
    end
  end

  assign rdata = rdata_reg;
  assign irq   = irq_reg;

endmodule

// File: tb/tb_sw_input_port.sv
// Randomised and directed bench for sw_input_port against a run-length model
// of the debounce rules and the register map.
module tb_sw_input_port;
  import sw_input_port_pkg::*;

  localparam int SW_W = 13;
  localparam int DC   = 4;

  logic            clk;
  logic            rst;
  logic [SW_W-1:0] sw;
  logic            rd_en;
  logic            wr_en;
  logic [1:0]      addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            irq;

  sw_input_port #(
    .SW_W        (SW_W),
    .CNT_W       (16),
    .DEBOUNCE_CYC(DC)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .sw   (sw),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .irq  (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: sync is sw delayed two cycles; a level is accepted once sync has
  // held it for DC+1 consecutive cycles while ENABLE is set.
  logic [SW_W-1:0] pipe0, pipe1, sync_now, run_val;
  int              run_len;
  logic [SW_W-1:0] m_stable, m_changed;
  logic            m_new, m_en, m_irq, m_acc, m_clr;
  logic [7:0]      m_evcnt;
  logic [31:0]     m_rdata, m_sel;
  bit              model_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      pipe0 = '0; pipe1 = '0; run_val = '0; run_len = 1;
      m_stable = '0; m_changed = '0; m_new = 0; m_en = 1;
      m_evcnt = 0; m_rdata = 0; m_irq = 0;
      model_valid = 1;
    end else if (model_valid) begin
      sync_now = pipe1;
      pipe1 = pipe0;
      pipe0 = sw;
      if (sync_now == run_val) begin
        if (run_len < 1000000) run_len++;
      end else begin
        run_val = sync_now;
        run_len = 1;
      end
      m_acc = (run_len >= DC + 1) && m_en && (run_val != m_stable);
      case (addr)
        SWP_DATA:    m_sel = 32'(m_stable);
        SWP_STATUS:  m_sel = {30'd0, m_en, m_new};
        SWP_CHANGED: m_sel = 32'(m_changed);
        default:     m_sel = 32'(m_evcnt);
      endcase
      if (rd_en) m_rdata = m_sel;
      m_irq = m_new & m_en;
      m_clr = wr_en && addr == SWP_STATUS && wdata[0];
      if (rd_en && addr == SWP_CHANGED) m_changed = '0;
      if (m_acc) begin
        m_changed = m_changed | (run_val ^ m_stable);
        m_stable  = run_val;
        m_new     = 1;
        m_evcnt   = m_evcnt + 8'd1;
      end else if (m_clr) begin
        m_new = 0;
      end
      if (wr_en && addr == SWP_STATUS) m_en = wdata[1];
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("rdata_model", rdata, m_rdata);
      check("irq_model", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd(input logic [1:0] a, input string nm, input logic [31:0] exp);
    rd_en = 1; addr = a;
    tick();
    rd_en = 0;
    check(nm, rdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1; addr = a; wdata = d;
    tick();
    wr_en = 0;
  endtask

  initial begin
    rst = 1; sw = '0; rd_en = 0; wr_en = 0; addr = 0; wdata = 0;
    tick();
    rst = 0;
    // Reset defaults
    check("reset_rdata", rdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    rd(SWP_STATUS, "reset_status", 32'h2);
    rd(SWP_EVCNT, "reset_evcnt", 32'h0);

    // Glitch shorter than the debounce window
    sw = 13'h001; ticks(3);
    sw = 13'h000; ticks(10);
    rd(SWP_DATA, "glitch_data", 32'h0);
    rd(SWP_STATUS, "glitch_status", 32'h2);
    rd(SWP_EVCNT, "glitch_evcnt", 32'h0);

    // Clean edge: accepted on the 7th edge after the change
    sw = 13'h1A5; ticks(6);
    rd(SWP_DATA, "edge_data_early", 32'h0);
    rd(SWP_DATA, "edge_data", 32'h1A5);
    check("edge_irq", {31'd0, irq}, 32'h1);
    rd(SWP_CHANGED, "changed_first", 32'h1A5);
    rd(SWP_CHANGED, "changed_cleared", 32'h0);
    rd(SWP_EVCNT, "edge_evcnt", 32'h1);
    rd(SWP_STATUS, "edge_status", 32'h3);

    // W1C of NEW
    wr(SWP_STATUS, 32'h3);
    tick();
    check("w1c_irq", {31'd0, irq}, 32'h0);
    rd(SWP_STATUS, "w1c_status", 32'h2);

    // CHANGED read colliding with an accept
    sw = 13'h1A4; ticks(8);
    sw = 13'h1A6; ticks(6);
    rd(SWP_CHANGED, "collide_old_mask", 32'h001);
    rd(SWP_CHANGED, "collide_new_mask", 32'h002);

    // W1C colliding with an accept: set wins
    sw = 13'h1A5; ticks(6);
    wr(SWP_STATUS, 32'h3);
    rd(SWP_STATUS, "collide_new", 32'h3);

    // Read and write together: pre-write value returned, ENABLE cleared
    rd_en = 1; wr_en = 1; addr = SWP_STATUS; wdata = 32'h1;
    tick();
    rd_en = 0; wr_en = 0;
    check("rdwr_prewrite", rdata, 32'h3);
    rd(SWP_STATUS, "disabled_status", 32'h0);

    // Acceptance held while disabled, released the cycle after re-enable
    sw = 13'h0FF; ticks(12);
    rd(SWP_DATA, "disabled_data", 32'h1A5);
    wr(SWP_STATUS, 32'h2);
    rd(SWP_DATA, "reenable_pre", 32'h1A5);
    rd(SWP_DATA, "reenable_data", 32'h0FF);

    // Reset in the middle of a debounce
    sw = 13'h0F0; ticks(3);
    sw = 13'h0FF; rst = 1;
    tick();
    rst = 0;
    check("midrst_rdata", rdata, 32'h0);
    rd(SWP_DATA, "midrst_data0", 32'h0);
    ticks(5);
    rd(SWP_DATA, "midrst_data_pre", 32'h0);
    rd(SWP_DATA, "midrst_data", 32'h0FF);
    rd(SWP_EVCNT, "midrst_evcnt", 32'h1);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 6) sw = SW_W'($urandom);
      else if (r < 12) sw = sw ^ (SW_W'(1) << $urandom_range(0, SW_W - 1));
      rd_en = 1'($urandom_range(0, 1));
      addr  = 2'($urandom_range(0, 3));
      wr_en = ($urandom_range(0, 9) == 0);
      wdata = {$urandom_range(0, 1) == 1 ? 30'h3FFFFFFF : 30'h0,
               ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1))};
      rst   = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 0; rd_en = 0; wr_en = 0;
    ticks(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
